// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, opcodes and the 4-bit ALUControl code space.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluXor  = 4'b0110;
  localparam logic [3:0] AluSll  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;
  localparam logic [3:0] AluSltu = 4'b1010;

  // Codes beyond slt only exist on the 4-bit ALU.
  function automatic logic is_ext_op(logic [3:0] code);
    return code > AluSlt;
  endfunction

endpackage

// File: rtl/alu_decoder_param.sv
// Combinational ALUControl decode for R/I-type instructions, flagging
// encodings the configured ALU cannot execute.
module alu_decoder_param
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic                  is_rtype_i,
  input  logic [2:0]            func3_i,
  input  logic [6:0]            func7_i,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic                  illegal_o
);

  logic [3:0] code;
  logic       f7_base;
  logic       f7_alt;
  logic       bad;

  assign f7_base = (func7_i == F7Base);
  assign f7_alt  = (func7_i == F7Alt);

  always_comb begin
    code = AluAdd;
    bad  = 1'b0;
    case (func3_i)
      3'b000: code = (is_rtype_i && f7_alt) ? AluSub : AluAdd;
      3'b001: begin
        code = AluSll;
        bad  = !f7_base;
      end
      3'b010: begin
        code = AluSlt;
        bad  = is_rtype_i && f7_alt;
      end
      3'b011: begin
        code = AluSltu;
        bad  = is_rtype_i && f7_alt;
      end
      3'b100: begin
        code = AluXor;
        bad  = is_rtype_i && f7_alt;
      end
      3'b101: begin
        code = f7_alt ? AluSra : AluSrl;
        bad  = !(f7_base || f7_alt);
      end
      3'b110: begin
        code = AluOr;
        bad  = is_rtype_i && f7_alt;
      end
      3'b111: begin
        code = AluAnd;
        bad  = is_rtype_i && f7_alt;
      end
      default: ;
    endcase
    // On R-type func7 is an opcode extension; on I-type it is immediate bits.
    if (is_rtype_i && !(f7_base || f7_alt)) bad = 1'b1;
    if (ALU_CTRL_W < 4 && is_ext_op(code)) bad = 1'b1;
  end

  assign alu_ctrl_o = code[ALU_CTRL_W-1:0];
  assign illegal_o  = bad;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready and traps unsupported encodings.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter bit          MEM_WAIT   = 1'b1,
  parameter bit          TRAP_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic                  RegWrite,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  illegal_instr
);

  localparam logic [ALU_CTRL_W-1:0] AluAddW = AluAdd[ALU_CTRL_W-1:0];
  localparam logic [ALU_CTRL_W-1:0] AluSubW = AluSub[ALU_CTRL_W-1:0];
  localparam state_e StIllegal = TRAP_EN ? StTrap : StFetch;

  state_e                  state_q, state_d;
  logic                    ready;
  logic                    is_rtype;
  logic [ALU_CTRL_W-1:0]   dec_alu;
  logic                    dec_illegal;
  logic                    beq_legal;
  logic                    beq_take;

  assign ready     = MEM_WAIT ? mem_ready : 1'b1;
  assign is_rtype  = (op == OpRType);
  assign beq_legal = (func3 == 3'b000) || (func3 == 3'b001);
  assign beq_take  = beq_legal && (func3[0] ? !zero : zero);

  alu_decoder_param #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_dec (
    .is_rtype_i(is_rtype),
    .func3_i   (func3),
    .func7_i   (func7),
    .alu_ctrl_o(dec_alu),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = dec_illegal ? StIllegal : StExecR;
          OpIType:         state_d = dec_illegal ? StIllegal : StExecI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StIllegal;
        endcase
      end
      StMemAdr:   state_d = (op == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  if (ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (ready) state_d = StFetch;
      StExecR,
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = beq_legal ? StFetch : StIllegal;
      StJal:      state_d = StAluWb;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  // Reset gates every output asynchronously so an abandoned access cannot strobe.
  always_comb begin
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ImmSrc        = 2'b00;
    RegWrite      = 1'b0;
    ALUControl    = AluAddW;
    illegal_instr = 1'b0;
    if (rst) begin
      case (state_q)
        StFetch: begin
          IRWrite   = ready;
          PCWrite   = ready;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        StDecode: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = 2'b10;
        end
        StMemAdr: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == OpStore) ? 2'b01 : 2'b00;
        end
        StMemRead:  AdrSrc = 1'b1;
        StMemWb: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        StMemWrite: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        StExecR: begin
          ALUSrcA    = 2'b10;
          ALUControl = dec_alu;
        end
        StExecI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = dec_alu;
        end
        StAluWb:    RegWrite = 1'b1;
        StBeq: begin
          ALUSrcA    = 2'b10;
          ALUControl = AluSubW;
          PCWrite    = beq_take;
        end
        StJal: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        StTrap:     illegal_instr = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: three configurations share stimulus; a per-instruction
// cycle template built from the instruction class predicts every output.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic       rw;
    logic [3:0] alu;
    logic       ill;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    waits;
    bit    gate;
  } step_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] f3 = '0;
  logic [6:0] f7 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pcw_w [3];
  logic       adr_w [3];
  logic       memw_w[3];
  logic       irw_w [3];
  logic [1:0] rs_w  [3];
  logic [1:0] sa_w  [3];
  logic [1:0] sb_w  [3];
  logic [1:0] imm_w [3];
  logic       rw_w  [3];
  logic       ill_w [3];
  logic [2:0] alu0_w;
  logic [3:0] alu1_w;
  logic [2:0] alu2_w;

  int    checks = 0;
  int    errors = 0;
  step_t tmpl[$];
  bit    tmpl_traps;

  initial forever #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: 4-bit ALU. Instance 2: no wait, no trap.
  multicycle_control_unit u0 (
    .clk(clk), .rst(rst), .op(op), .func3(f3), .func7(f7), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(pcw_w[0]), .AdrSrc(adr_w[0]), .MemWrite(memw_w[0]),
    .IRWrite(irw_w[0]), .ResultSrc(rs_w[0]), .ALUSrcA(sa_w[0]), .ALUSrcB(sb_w[0]),
    .ImmSrc(imm_w[0]), .RegWrite(rw_w[0]), .ALUControl(alu0_w), .illegal_instr(ill_w[0])
  );

  multicycle_control_unit #(.ALU_CTRL_W(4)) u1 (
    .clk(clk), .rst(rst), .op(op), .func3(f3), .func7(f7), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(pcw_w[1]), .AdrSrc(adr_w[1]), .MemWrite(memw_w[1]),
    .IRWrite(irw_w[1]), .ResultSrc(rs_w[1]), .ALUSrcA(sa_w[1]), .ALUSrcB(sb_w[1]),
    .ImmSrc(imm_w[1]), .RegWrite(rw_w[1]), .ALUControl(alu1_w), .illegal_instr(ill_w[1])
  );

  multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_WAIT(1'b0), .TRAP_EN(1'b0)) u2 (
    .clk(clk), .rst(rst), .op(op), .func3(f3), .func7(f7), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(pcw_w[2]), .AdrSrc(adr_w[2]), .MemWrite(memw_w[2]),
    .IRWrite(irw_w[2]), .ResultSrc(rs_w[2]), .ALUSrcA(sa_w[2]), .ALUSrcB(sb_w[2]),
    .ImmSrc(imm_w[2]), .RegWrite(rw_w[2]), .ALUControl(alu2_w), .illegal_instr(ill_w[2])
  );

  function automatic int p_w(int s);
    return (s == 1) ? 4 : 3;
  endfunction

  function automatic bit p_mw(int s);
    return s != 2;
  endfunction

  function automatic bit p_te(int s);
    return s != 2;
  endfunction

  function automatic outs_t observe(int s);
    outs_t r;
    r.pcw = pcw_w[s];  r.adr = adr_w[s];  r.memw = memw_w[s]; r.irw = irw_w[s];
    r.rs  = rs_w[s];   r.sa  = sa_w[s];   r.sb   = sb_w[s];   r.imm = imm_w[s];
    r.rw  = rw_w[s];   r.ill = ill_w[s];
    case (s)
      0:       r.alu = {1'b0, alu0_w};
      1:       r.alu = alu1_w;
      default: r.alu = {1'b0, alu2_w};
    endcase
    return r;
  endfunction

  // Reference ALU decode by mnemonic; returns 0 when the encoding is not executable.
  function automatic bit alu_ref(int w, bit rt, logic [2:0] f3v, logic [6:0] f7v,
                                 output logic [3:0] code);
    bit base, alt, ok, needs4, no_alt;
    base = (f7v == 7'b0000000);
    alt  = (f7v == 7'b0100000);
    ok = 1; needs4 = 0; no_alt = 0;
    case (f3v)
      3'b000: code = (rt && alt) ? 4'd1 : 4'd0;                            // add/sub
      3'b010: begin code = 4'd5;  no_alt = 1; end                          // slt
      3'b110: begin code = 4'd3;  no_alt = 1; end                          // or
      3'b111: begin code = 4'd2;  no_alt = 1; end                          // and
      3'b100: begin code = 4'd6;  no_alt = 1; needs4 = 1; end              // xor
      3'b011: begin code = 4'd10; no_alt = 1; needs4 = 1; end              // sltu
      3'b001: begin code = 4'd7;  needs4 = 1; if (!base) ok = 0; end       // sll
      default: begin                                                       // srl/sra
        code = alt ? 4'd9 : 4'd8; needs4 = 1;
        if (!base && !alt) ok = 0;
      end
    endcase
    if (rt && !base && !alt) ok = 0;
    if (rt && alt && no_alt) ok = 0;
    if (needs4 && w < 4) ok = 0;
    return ok;
  endfunction

  function automatic void push(outs_t o, bit w, bit g);
    step_t st;
    st.o = o; st.waits = w; st.gate = g;
    tmpl.push_back(st);
  endfunction

  function automatic void push_trap(int s);
    outs_t o;
    o = '0; o.ill = 1'b1;
    if (p_te(s)) begin
      tmpl_traps = 1;
      for (int i = 0; i < 10; i++) push(o, 0, 0);
    end
  endfunction

  function automatic void build(int s, logic [6:0] opv, logic [2:0] f3v, logic [6:0] f7v,
                                logic zv);
    outs_t      o;
    logic [3:0] code;
    bit         ok;
    tmpl.delete();
    tmpl_traps = 0;
    o = '0; o.pcw = 1; o.irw = 1; o.sb = 2'b10; o.rs = 2'b10; push(o, 1, 1);   // fetch
    o = '0; o.sa = 2'b01; o.sb = 2'b01; o.imm = 2'b10;       push(o, 0, 0);   // decode
    case (opv)
      7'b0000011: begin                                                      // lw
        o = '0; o.sa = 2'b10; o.sb = 2'b01;  push(o, 0, 0);
        o = '0; o.adr = 1;                   push(o, 1, 0);
        o = '0; o.rs = 2'b01; o.rw = 1;      push(o, 0, 0);
      end
      7'b0100011: begin                                                      // sw
        o = '0; o.sa = 2'b10; o.sb = 2'b01; o.imm = 2'b01; push(o, 0, 0);
        o = '0; o.adr = 1; o.memw = 1;                     push(o, 1, 0);
      end
      7'b0110011, 7'b0010011: begin                                          // R / I
        ok = alu_ref(p_w(s), opv == 7'b0110011, f3v, f7v, code);
        if (!ok) push_trap(s);
        else begin
          o = '0; o.sa = 2'b10; o.sb = (opv == 7'b0110011) ? 2'b00 : 2'b01; o.alu = code;
          push(o, 0, 0);
          o = '0; o.rw = 1; push(o, 0, 0);
        end
      end
      7'b1100011: begin                                                      // branch
        o = '0; o.sa = 2'b10; o.alu = 4'd1;
        if (f3v == 3'b000) o.pcw = zv;
        else if (f3v == 3'b001) o.pcw = !zv;
        push(o, 0, 0);
        if (f3v != 3'b000 && f3v != 3'b001) push_trap(s);
      end
      7'b1101111: begin                                                      // jal
        o = '0; o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1; push(o, 0, 0);
        o = '0; o.rw = 1; push(o, 0, 0);
      end
      default: push_trap(s);
    endcase
  endfunction

  // Starts and ends on a falling edge with the selected instance in FETCH.
  task automatic run_instr(input int s, input logic [6:0] opv, input logic [2:0] f3v,
                           input logic [6:0] f7v, input logic zv, input bit rnd,
                           input int stall_step, input int stall_n, input string nm);
    op = opv; f3 = f3v; f7 = f7v; zero = zv;
    build(s, opv, f3v, f7v, zv);
    for (int k = 0; k < tmpl.size(); k++) begin
      int stalls;
      bit adv;
      stalls = 0; adv = 0;
      while (!adv) begin
        bit    r, eff;
        outs_t e, g;
        if (rnd) r = ($urandom_range(3) != 0);
        else     r = !(k == stall_step && stalls < stall_n);
        mem_ready = r;
        #1;
        eff = p_mw(s) ? r : 1'b1;
        e = tmpl[k].o;
        if (tmpl[k].gate) begin
          e.pcw = eff; e.irw = eff;
        end
        g = observe(s);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL %s step %0d: got %h expected %h", nm, k, g, e);
        end
        @(negedge clk);
        stalls++;
        adv = !tmpl[k].waits || eff || stalls >= 64;
      end
    end
  endtask

  task automatic do_reset();
    outs_t g;
    rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      g = observe(s);
      checks++;
      if (g !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst %0d: got %h expected 0", s, g);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // FETCH with memory not ready: must hold without loading PC/IR.
  task automatic check_fetch_idle(input int s, input string nm);
    outs_t e, g;
    mem_ready = 1'b0;
    #1;
    e = '0; e.sb = 2'b10; e.rs = 2'b10;
    g = observe(s);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s fetch_idle: got %h expected %h", nm, g, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_rtype();
    do_reset();
    run_instr(0, 7'b0110011, 3'b000, 7'b0000000, 0, 0, -1, 0, "add");
    check_fetch_idle(0, "add_len");
    run_instr(0, 7'b0110011, 3'b000, 7'b0100000, 0, 0, -1, 0, "sub");
    run_instr(0, 7'b0110011, 3'b111, 7'b0000000, 0, 0, -1, 0, "and");
    run_instr(0, 7'b0110011, 3'b100, 7'b0000000, 0, 0, -1, 0, "xor_w3_trap");
    do_reset();
  endtask

  task automatic test_load_stall();
    do_reset();
    run_instr(0, 7'b0000011, 3'b010, 7'b0000000, 0, 0, 3, 2, "lw_stall");
    run_instr(0, 7'b0100011, 3'b010, 7'b0000000, 0, 0, 3, 3, "sw_stall");
    run_instr(0, 7'b0000011, 3'b010, 7'b0000000, 0, 0, 0, 2, "lw_fetch_stall");
    check_fetch_idle(0, "lw_len");
  endtask

  task automatic test_branch();
    do_reset();
    run_instr(0, 7'b1100011, 3'b000, 7'b0000000, 1, 0, -1, 0, "beq_taken");
    run_instr(0, 7'b1100011, 3'b000, 7'b0000000, 0, 0, -1, 0, "beq_not_taken");
    run_instr(0, 7'b1100011, 3'b001, 7'b0000000, 0, 0, -1, 0, "bne_taken");
    run_instr(0, 7'b1101111, 3'b000, 7'b0000000, 0, 0, -1, 0, "jal");
    run_instr(0, 7'b1100011, 3'b100, 7'b0000000, 1, 0, -1, 0, "blt_trap");
    do_reset();
  endtask

  task automatic test_trap();
    do_reset();
    run_instr(0, 7'b1111111, 3'b000, 7'b0000000, 0, 0, -1, 0, "illegal_op");
    do_reset();
  endtask

  task automatic test_alu_w4();
    do_reset();
    run_instr(1, 7'b0010011, 3'b000, 7'b0100000, 0, 0, -1, 0, "addi_f7alt_w4");
    run_instr(1, 7'b0110011, 3'b100, 7'b0000000, 0, 0, -1, 0, "xor_w4");
    run_instr(1, 7'b0110011, 3'b101, 7'b0100000, 0, 0, -1, 0, "sra_w4");
    run_instr(1, 7'b0110011, 3'b011, 7'b0000000, 0, 0, -1, 0, "sltu_w4");
    run_instr(1, 7'b0110011, 3'b000, 7'b0000001, 0, 0, -1, 0, "bad_f7_w4");
    do_reset();
    run_instr(0, 7'b0010011, 3'b000, 7'b0100000, 0, 0, -1, 0, "addi_f7alt_w3");
  endtask

  task automatic test_trap_disabled();
    do_reset();
    run_instr(2, 7'b1111111, 3'b000, 7'b0000000, 0, 0, -1, 0, "nop_illegal");
    run_instr(2, 7'b0000011, 3'b010, 7'b0000000, 0, 0, 3, 2, "lw_nowait");
    run_instr(2, 7'b0110011, 3'b100, 7'b0000000, 0, 0, -1, 0, "xor_nop");
    run_instr(2, 7'b0110011, 3'b000, 7'b0000000, 0, 0, -1, 0, "add_after_nop");
  endtask

  task automatic test_mid_write_reset();
    outs_t g;
    do_reset();
    op = 7'b0100011; f3 = 3'b010; f7 = '0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (memw_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL memwrite_hold: got %b expected 1", memw_w[0]);
    end
    #2 rst = 1'b0;
    #1;
    g = observe(0);
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL memwrite_async_reset: got %h expected 0", g);
    end
    @(negedge clk);
    rst = 1'b1;
    run_instr(0, 7'b0110011, 3'b110, 7'b0000000, 0, 0, -1, 0, "or_after_reset");
  endtask

  task automatic test_random();
    logic [6:0] opv, f7v;
    logic [2:0] f3v;
    for (int s = 0; s < 3; s++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(7))
          0:       opv = 7'b0000011;
          1:       opv = 7'b0100011;
          2, 3:    opv = 7'b0110011;
          4:       opv = 7'b0010011;
          5:       opv = 7'b1100011;
          6:       opv = 7'b1101111;
          default: opv = 7'($urandom);
        endcase
        case ($urandom_range(3))
          0, 1:    f7v = 7'b0000000;
          2:       f7v = 7'b0100000;
          default: f7v = 7'($urandom);
        endcase
        f3v = 3'($urandom);
        run_instr(s, opv, f3v, f7v, 1'($urandom), 1, -1, 0, "random");
        if (tmpl_traps) do_reset();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_rtype();
    test_load_stall();
    test_branch();
    test_trap();
    test_alu_w4();
    test_trap_disabled();
    test_mid_write_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
